// File: rtl/boot_loader.sv
// boot_loader: UART program loader. It holds the core in reset, receives a
// framed image (A5, LEN_LO, LEN_HI, 4*N data bytes, CSUM) over an 8N1 line,
// writes it word by word into program memory from address 0, and releases
// the core once the checksum matches.
module boot_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_WORDS    = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic        o_core_rst,
    output logic        o_busy,
    output logic        o_err
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam logic [31:0]      MAX_LEN   = 32'(MAX_WORDS);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    // Receive-side registers
    logic             r_rx_meta;
    logic             r_rx_sync;
    rx_state_t        r_rx_state;
    rx_state_t        w_rx_next;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic             r_rx_valid;
    logic             r_rx_ferr;
    logic             w_rx_half;
    logic             w_rx_full;

    // Loader registers
    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_len_lo;
    logic [15:0]      r_len;
    logic [15:0]      r_word_idx;
    logic [1:0]       r_byte_cnt;
    logic [7:0]       r_csum;
    logic [31:0]      r_word;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_data;

    logic             w_start;
    logic             w_cap_lo;
    logic             w_cap_hi;
    logic             w_take;
    logic             w_write;
    logic [15:0]      w_len;
    logic             w_len_ok;
    logic [31:0]      w_word;
    logic             w_last;

    assign w_rx_half = (r_rx_cnt == HALF_M1);
    assign w_rx_full = (r_rx_cnt == FULL_M1);

    // Two-flop synchronizer; both flops idle high so reset looks like an idle line.
    always_ff @(posedge i_clk or negedge i_rst) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values,
        // which is what makes the two synchronizer stages a real two-cycle delay.
        if (!i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // UART state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    // UART next state: start re-check at half bit, then full-bit sampling.
    always_comb begin
        // NOTE: the default assignment up front keeps this block free of latches.
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
            RX_START: if (w_rx_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_full && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_full) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // UART datapath: bit timing counter, LSB-first shifter, byte/framing strobes.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    // The detect cycle itself counts as the first clock of the start bit.
                    r_rx_cnt <= CNT_W'(1);
                    r_rx_bit <= '0;
                end
                RX_START: r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + CNT_W'(1);
                RX_DATA: begin
                    if (w_rx_full) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (w_rx_full) begin
                        r_rx_cnt <= '0;
                        if (r_rx_sync) r_rx_valid <= 1'b1;
                        else           r_rx_ferr  <= 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                default: r_rx_cnt <= '0;
            endcase
        end
    end

    assign w_len    = {r_rx_shift, r_len_lo};
    assign w_len_ok = (w_len != 16'd0) && ({16'd0, w_len} <= MAX_LEN);
    assign w_word   = {r_rx_shift, r_word[31:8]};
    assign w_last   = (r_word_idx == r_len - 16'd1);

    // Loader state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Loader next state and datapath controls, driven by the byte/framing strobes.
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_cap_lo = 1'b0;
        w_cap_hi = 1'b0;
        w_take   = 1'b0;
        w_write  = 1'b0;
        case (r_state)
            S_IDLE, S_ERROR: begin
                // Framing errors are dropped here; only a sync byte restarts a load.
                if (r_rx_valid && (r_rx_shift == SYNC_BYTE)) begin
                    w_next  = S_LEN_LO;
                    w_start = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (r_rx_ferr) begin
                    w_next = S_ERROR;
                end else if (r_rx_valid) begin
                    w_cap_lo = 1'b1;
                    w_next   = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (r_rx_ferr) begin
                    w_next = S_ERROR;
                end else if (r_rx_valid) begin
                    w_cap_hi = 1'b1;
                    w_next   = w_len_ok ? S_DATA : S_ERROR;
                end
            end
            S_DATA: begin
                if (r_rx_ferr) begin
                    w_next = S_ERROR;
                end else if (r_rx_valid) begin
                    w_take = 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        w_write = 1'b1;
                        if (w_last) w_next = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (r_rx_ferr) begin
                    w_next = S_ERROR;
                end else if (r_rx_valid) begin
                    w_next = (r_rx_shift == r_csum) ? S_DONE : S_ERROR;
                end
            end
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Loader datapath: length capture, checksum, word assembly, write port.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_csum     <= '0;
            r_word     <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_mem_we <= w_write;
            if (w_start) begin
                r_word_idx <= '0;
                r_byte_cnt <= '0;
                r_csum     <= '0;
            end
            if (w_cap_lo) r_len_lo <= r_rx_shift;
            if (w_cap_hi) r_len    <= w_len;
            if (w_take) begin
                r_csum     <= r_csum + r_rx_shift;
                r_word     <= w_word;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_write) begin
                r_mem_addr <= {14'd0, r_word_idx, 2'b00};
                r_mem_data <= w_word;
                r_word_idx <= r_word_idx + 16'd1;
            end
        end
    end

    assign o_mem_we   = r_mem_we;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_data = r_mem_data;
    assign o_core_rst = (r_state == S_DONE);
    assign o_err      = (r_state == S_ERROR);
    assign o_busy     = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CSUM);

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: drives framed images over the serial line and compares the
// observed memory writes and status against expectations built from the
// frame contents (word list, length rules, modulo-256 data checksum).
module tb_boot_loader;

    localparam int C    = 4;
    localparam int MAXW = 4;
    // Clocks from a start-bit fall to the first sample of a registered response.
    localparam int LAT  = 3 + 9 * C + C / 2;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic        i_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_rx  = 1'b1;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic        o_core_rst;
    logic        o_busy;
    logic        o_err;

    always #5 i_clk = ~i_clk;

    boot_loader #(.CLKS_PER_BIT(C), .MAX_WORDS(MAXW)) dut (
        .i_clk      (i_clk),
        .i_rst      (rst_n),
        .i_rx       (i_rx),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_data (o_mem_data),
        .o_core_rst (o_core_rst),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    time         q_we_t[$];
    time         fall_t[$];
    time         t_core_rise, t_busy_fall, t_err_rise;
    bit          busy_seen;
    logic        prev_we = 1'b0, prev_core = 1'b0, prev_busy = 1'b0, prev_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Observer on the falling edge: logs writes, their timing, and status edges.
    always @(negedge i_clk) begin
        if (o_mem_we) begin
            q_addr.push_back(o_mem_addr);
            q_data.push_back(o_mem_data);
            check("we_one_cycle", {31'd0, prev_we}, 32'd0);
            if (!prev_we) q_we_t.push_back($time);
        end
        if (o_core_rst && !prev_core) t_core_rise = $time;
        if (!o_busy && prev_busy)     t_busy_fall = $time;
        if (o_err && !prev_err)       t_err_rise  = $time;
        if (o_busy)                   busy_seen   = 1'b1;
        prev_we   = o_mem_we;
        prev_core = o_core_rst;
        prev_busy = o_busy;
        prev_err  = o_err;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        q_addr.delete();
        q_data.delete();
        q_we_t.delete();
        fall_t.delete();
        busy_seen = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rx  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        clear_obs();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
        @(negedge i_clk);
        i_rx = 1'b0;
        fall_t.push_back($time);
        repeat (C) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (C) @(negedge i_clk);
        end
        i_rx = stop;
        repeat (C) @(negedge i_clk);
        i_rx = 1'b1;
        // A low stop bit looks like a new start edge; let that phantom byte finish.
        if (!stop) repeat (12 * C) @(negedge i_clk);
    endtask

    task automatic send_bytes(input byte_q_t fr, input int first);
        for (int i = first; i < fr.size(); i++) send_byte(fr[i]);
    endtask

    task automatic settle();
        repeat (4) @(negedge i_clk);
    endtask

    // Frame from a word list: sync, length, little-endian data, data-only sum plus adj.
    function automatic byte_q_t make_frame(input word_q_t words, input logic [15:0] len,
                                           input logic [7:0] adj);
        byte_q_t    fr;
        logic [7:0] sum;
        logic [31:0] w;
        sum = 8'd0;
        fr.push_back(8'hA5);
        fr.push_back(len[7:0]);
        fr.push_back(len[15:8]);
        foreach (words[k]) begin
            w = words[k];
            for (int j = 0; j < 4; j++) begin
                fr.push_back(w[8*j +: 8]);
                sum = sum + w[8*j +: 8];
            end
        end
        fr.push_back(sum + adj);
        return fr;
    endfunction

    task automatic check_writes(input string tag, input word_q_t words);
        check({tag, "_count"}, 32'(q_addr.size()), 32'(words.size()));
        foreach (words[k]) begin
            if (k < q_addr.size()) begin
                check({tag, "_addr"}, q_addr[k], 32'(4 * k));
                check({tag, "_data"}, q_data[k], words[k]);
            end
        end
    endtask

    task automatic check_status(input string tag, input logic core, input logic busy,
                                input logic err);
        check({tag, "_core_rst"}, {31'd0, o_core_rst}, {31'd0, core});
        check({tag, "_busy"},     {31'd0, o_busy},     {31'd0, busy});
        check({tag, "_err"},      {31'd0, o_err},      {31'd0, err});
    endtask

    word_q_t ref_words;
    word_q_t empty_q;
    word_q_t rnd_words;
    byte_q_t fr;
    byte_q_t fr_bad;

    initial begin
        ref_words = '{32'h12345678, 32'hDEADBEEF};
        fr        = make_frame(ref_words, 16'd2, 8'd0);
        fr_bad    = make_frame(ref_words, 16'd2, 8'd1);

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_we",   {31'd0, o_mem_we}, 32'd0);
        check("rst_addr", o_mem_addr, 32'd0);
        check("rst_data", o_mem_data, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        clear_obs();

        // Valid load with exact write / release timing
        send_bytes(fr, 0);
        settle();
        check_writes("valid", ref_words);
        check_status("valid", 1'b1, 1'b0, 1'b0);
        if (q_we_t.size() == 2 && fall_t.size() == 12) begin
            check("valid_we0_lat", 32'(q_we_t[0] - fall_t[6]), 32'(LAT * 10));
            check("valid_we1_lat", 32'(q_we_t[1] - fall_t[10]), 32'(LAT * 10));
            check("valid_core_lat", 32'(t_core_rise - fall_t[11]), 32'(LAT * 10));
            check("valid_busy_fall", 32'(t_busy_fall), 32'(t_core_rise));
        end else begin
            check("valid_event_count", 32'(q_we_t.size()), 32'd2);
        end

        // Bad checksum, then retry without reset
        do_reset();
        send_bytes(fr_bad, 0);
        settle();
        check_writes("badsum", ref_words);
        check_status("badsum", 1'b0, 1'b0, 1'b1);
        if (fall_t.size() == 12)
            check("badsum_err_lat", 32'(t_err_rise - fall_t[11]), 32'(LAT * 10));
        clear_obs();
        send_byte(8'hA5);
        settle();
        check_status("retry_sync", 1'b0, 1'b1, 1'b0);
        send_bytes(fr, 1);
        settle();
        check_writes("retry", ref_words);
        check_status("retry", 1'b1, 1'b0, 1'b0);

        // Length bounds
        do_reset();
        send_bytes(make_frame(empty_q, 16'd0, 8'd0), 0);
        settle();
        check_writes("len0", empty_q);
        check_status("len0", 1'b0, 1'b0, 1'b1);
        do_reset();
        send_bytes(make_frame(empty_q, 16'(MAXW + 1), 8'd0), 0);
        settle();
        check_writes("lenmax", empty_q);
        check_status("lenmax", 1'b0, 1'b0, 1'b1);

        // Glitch and idle noise, then a normal load must still frame correctly
        do_reset();
        @(negedge i_clk);
        i_rx = 1'b0;
        @(negedge i_clk);
        i_rx = 1'b1;
        repeat (12 * C) @(negedge i_clk);
        send_byte(8'h00);
        send_byte(8'hFF);
        settle();
        check("noise_busy_seen", {31'd0, busy_seen}, 32'd0);
        check_status("noise", 1'b0, 1'b0, 1'b0);
        send_bytes(fr, 0);
        settle();
        check_writes("noise_load", ref_words);
        check_status("noise_load", 1'b1, 1'b0, 1'b0);

        // Framing error in DATA
        do_reset();
        send_bytes(make_frame(empty_q, 16'd1, 8'd0), 0);
        send_byte(8'h11, 1'b0);
        check_status("ferr", 1'b0, 1'b0, 1'b1);

        // Reset mid-load, then a fresh load, then the DONE lock
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(fr[i]);
        repeat (2) @(negedge i_clk);
        check("midrst_pre_busy", {31'd0, o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_we",   {31'd0, o_mem_we}, 32'd0);
        check("midrst_addr", o_mem_addr, 32'd0);
        check("midrst_data", o_mem_data, 32'd0);
        check_status("midrst", 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge i_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        clear_obs();
        send_bytes(fr, 0);
        settle();
        check_writes("after_rst", ref_words);
        check_status("after_rst", 1'b1, 1'b0, 1'b0);
        clear_obs();
        send_bytes(fr, 0);
        settle();
        check_writes("done_lock", empty_q);
        check("done_lock_busy_seen", {31'd0, busy_seen}, 32'd0);
        check_status("done_lock", 1'b1, 1'b0, 1'b0);

        // Randomized frames: random length, data, idle noise and checksum corruption
        for (int it = 0; it < 8; it++) begin
            int         n;
            bit         bad;
            logic [7:0] nb;
            do_reset();
            rnd_words.delete();
            n   = $urandom_range(1, MAXW);
            bad = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < n; k++) rnd_words.push_back($urandom);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h5A;
                send_byte(nb);
            end
            send_bytes(make_frame(rnd_words, 16'(n), bad ? 8'($urandom_range(1, 255)) : 8'd0), 0);
            settle();
            check_writes($sformatf("rnd%0d", it), rnd_words);
            check_status($sformatf("rnd%0d", it), !bad, 1'b0, bad);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
